uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter. It accepts a byte on a parallel bus into a holding register, then loads a shift register. On command it emits an 8N1 frame on `Serial_out`: a low start bit, 8 data bits LSB first, then a high stop bit. It sits between the bridge's byte source (CPU/CAN side) and the UART TX pin; bit timing is derived from `clock` via a clocks-per-bit counter.

## Interface
- `WORD_SIZE`, 8, data bits per frame.
- `CLKS_PER_BIT`, 1, clock cycles each serial bit is held (1 = one bit per clock; ≥1).

- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on rising `clock`).
- `Data_Bus`  in  WORD_SIZE  parallel byte to transmit.
- `Load_XMT_datareg`  in  1  load `Data_Bus` into the holding register.
- `Byte_ready`  in  1  holding register valid; load the shift register (honoured in IDLE only).
- `T_byte`  in  1  start transmission (honoured in WAITING only).
- `Serial_out`  out  1  serial line; idles high.

## Operation
- Registers:
  - `XMT_datareg[WORD_SIZE-1:0]`: holding register.
  - `XMT_shftreg[WORD_SIZE:0]`: shift register; `Serial_out = XMT_shftreg[0]`.
  - `bit_count`: 0..WORD_SIZE+1.
  - `clk_count`: 0..CLKS_PER_BIT-1.
  - `state`: IDLE, WAITING or SENDING.
- Reset (`reset`=0 at an edge):
  - state IDLE.
  - `XMT_shftreg` all 1s, so `Serial_out`=1.
  - `XMT_datareg`=0.
  - `bit_count`=0 and `clk_count`=0.
  - Reset overrides all other inputs.
  - Reset mid-frame aborts immediately; the line returns high on the next cycle.
- Holding register:
  - `Load_XMT_datareg`=1 at an edge writes `XMT_datareg <= Data_Bus`.
  - This applies in any state.
  - It never disturbs a frame in progress.
- IDLE:
  - `Byte_ready`=1 loads `XMT_shftreg <= {source, 1'b1}` and moves to WAITING.
  - The source is `Data_Bus` if `Load_XMT_datareg` is also 1 that cycle (bypass), otherwise `XMT_datareg`.
  - The line stays high.
  - `T_byte` is ignored in IDLE.
- WAITING:
  - The line stays high.
  - `T_byte`=1 forces `XMT_shftreg[0] <= 0` (start bit) and moves to SENDING.
  - On that transition, `bit_count` and `clk_count` are cleared.
  - `Byte_ready` is ignored in WAITING.
- SENDING:
  - `clk_count` increments every cycle.
  - When `clk_count`=CLKS_PER_BIT-1:
    - If `bit_count` ≠ WORD_SIZE+1: `XMT_shftreg <= {1'b1, XMT_shftreg[WORD_SIZE:1]}`, `bit_count` increments, and `clk_count` clears.
    - If `bit_count` = WORD_SIZE+1: `bit_count` and `clk_count` clear and the state returns to IDLE.
  - `Byte_ready` and `T_byte` are ignored in SENDING.
- Back in IDLE with `Byte_ready` still 1: the next cycle reloads the shift register and re-enters WAITING. No frame is sent without a fresh `T_byte` in WAITING.

## Timing
- Let S be the edge at which `T_byte` is sampled 1 in WAITING, and B = CLKS_PER_BIT.
- Line sequence after S:
  - Start bit (`Serial_out`=0) from S for B cycles.
  - d0 from S+B, d1 from S+2B, … d7 from S+8B.
  - Stop bit (1) from S+9B.
- State timing:
  - The state returns to IDLE at S+10B.
  - The line stays 1 from S+9B onward (stop bit, then idle).
  - Frame length is 10B cycles.
- `Byte_ready` sampled at edge E in IDLE gives WAITING after E; the earliest start edge is E+1.
- `Serial_out` is purely registered; no combinational path from inputs.
- All shift-register contents are unsigned bit vectors; `bit_count` must hold WORD_SIZE+1.

## Test plan
- Reset and idle:
  - Stimulus: `reset`=0 for 2 cycles, then release with all inputs 0.
  - Required: `Serial_out`=1 continuously, state IDLE.
- Send 'A' (0x41), B=1:
  - Stimulus: `Load_XMT_datareg`=1 and `Byte_ready`=1 in the same cycle with `Data_Bus`=0x41, then `T_byte`=1 next cycle.
  - Required: `Serial_out` from S = 0,1,0,0,0,0,0,1,0,1 per clock, then stays 1.
- Preloaded holding register:
  - Stimulus: load 0xA5, wait 3 cycles, pulse `Byte_ready`, wait 2 cycles in WAITING, pulse `T_byte`.
  - Required: line high while waiting; frame 0,1,0,1,0,0,1,0,1,1.
- Ignored inputs mid-frame:
  - Stimulus: during SENDING, load 0xFF via `Load_XMT_datareg`, toggle `Byte_ready` and `T_byte`.
  - Required: the current frame completes unchanged; `XMT_datareg`=0xFF afterwards.
- Reset mid-frame:
  - Stimulus: assert `reset`=0 at bit d3.
  - Required: `Serial_out`=1 on the next cycle, state IDLE; a new `Byte_ready`/`T_byte` then sends a full, correct frame.
- Slow bit rate:
  - Stimulus: CLKS_PER_BIT=4, send 0x41.
  - Required: each bit held exactly 4 cycles; return to IDLE at S+40.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-serial 8N1 UART transmitter with holding and shift registers
module uart_tx #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] Data_Bus,
    input  logic                 Load_XMT_datareg,
    input  logic                 Byte_ready,
    input  logic                 T_byte,
    output logic                 Serial_out
);

    // clk_count needs at least one bit even when every bit lasts a single clock
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // bit_count must reach WORD_SIZE+1 (start + data + stop)
    localparam int BIT_W = $clog2(WORD_SIZE + 2);

    localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SENDING = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WORD_SIZE-1:0] XMT_datareg;
    logic [WORD_SIZE:0]   XMT_shftreg;
    logic [BIT_W-1:0]     bit_count;
    logic [CNT_W-1:0]     clk_count;

    logic [WORD_SIZE-1:0] shift_src;
    logic                 bit_tick;
    logic                 frame_end;

    logic                 load_shift;
    logic                 start_frame;
    logic                 shift_bit;
    logic                 count_run;

    // A byte presented together with Load_XMT_datareg bypasses the holding register
    assign shift_src = Load_XMT_datareg ? Data_Bus : XMT_datareg;

    // End of the current bit period, and end of the stop bit
    assign bit_tick  = (state == SENDING) && (clk_count == CLK_LAST);
    assign frame_end = bit_tick && (bit_count == BIT_LAST);

    // The line is driven straight from the shift register LSB, so it is glitch-free
    assign Serial_out = XMT_shftreg[0];

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: Byte_ready only matters in IDLE, T_byte only in WAITING
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Byte_ready) begin
                    next_state = WAITING;
                end
            end
            WAITING: begin
                if (T_byte) begin
                    next_state = SENDING;
                end
            end
            SENDING: begin
                if (frame_end) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: datapath strobes for the current state
    always_comb begin
        load_shift  = 1'b0;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        count_run   = 1'b0;
        case (state)
            IDLE: begin
                load_shift = Byte_ready;
            end
            WAITING: begin
                start_frame = T_byte;
            end
            SENDING: begin
                count_run = 1'b1;
                shift_bit = bit_tick && !frame_end;
            end
            default: begin
                load_shift = 1'b0;
            end
        endcase
    end

    // Holding register: writable in any state, never touches the shifter
    always_ff @(posedge clock) begin
        if (!reset) begin
            XMT_datareg <= '0;
        end else if (Load_XMT_datareg) begin
            XMT_datareg <= Data_Bus;
        end
    end

    // Shift register: load with a high LSB, drop the start bit in, then shift ones in from the top
    always_ff @(posedge clock) begin
        if (!reset) begin
            XMT_shftreg <= '1;
        end else if (load_shift) begin
            XMT_shftreg <= {shift_src, 1'b1};
        end else if (start_frame) begin
            XMT_shftreg[0] <= 1'b0;
        end else if (shift_bit) begin
            XMT_shftreg <= {1'b1, XMT_shftreg[WORD_SIZE:1]};
        end
    end

    // Bit timing: clk_count paces each bit, bit_count tracks position in the frame
    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_count <= '0;
            clk_count <= '0;
        end else if (start_frame) begin
            bit_count <= '0;
            clk_count <= '0;
        end else if (count_run) begin
            if (clk_count == CLK_LAST) begin
                clk_count <= '0;
                if (frame_end) begin
                    bit_count <= '0;
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end else begin
                clk_count <= clk_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clock;
    logic       reset;
    logic [7:0] Data_Bus;
    logic       Load_XMT_datareg;
    logic       Byte_ready;
    logic       T_byte;
    logic       serial1;
    logic       serial4;

    int tests_run;
    int tests_failed;

    // Hand-derived frames, bit i = line level i bit-periods after the start edge
    localparam logic [9:0] FRAME_41 = 10'b1010000010;
    localparam logic [9:0] FRAME_A5 = 10'b1101001010;
    localparam logic [9:0] FRAME_3C = 10'b1001111000;
    localparam logic [9:0] FRAME_96 = 10'b1100101100;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAITING = 2'd1;
    localparam logic [1:0] ST_SENDING = 2'd2;

    uart_tx #(.WORD_SIZE(8), .CLKS_PER_BIT(1)) dut1 (
        .clock            (clock),
        .reset            (reset),
        .Data_Bus         (Data_Bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte),
        .Serial_out       (serial1)
    );

    uart_tx #(.WORD_SIZE(8), .CLKS_PER_BIT(4)) dut4 (
        .clock            (clock),
        .reset            (reset),
        .Data_Bus         (Data_Bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte),
        .Serial_out       (serial4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clock out the rest of a B=1 frame after the start edge; optionally poke inputs mid-frame
    task automatic run_frame(input string tag, input logic [9:0] exp, input bit disturb);
        check({tag, "_start"}, 32'(serial1), 32'(exp[0]));
        for (int i = 1; i < 10; i++) begin
            if (disturb && i >= 2 && i <= 5) begin
                Load_XMT_datareg = 1'b1;
                Data_Bus         = 8'hFF;
                Byte_ready       = i[0];
                T_byte           = ~i[0];
            end else begin
                Load_XMT_datareg = 1'b0;
                Byte_ready       = 1'b0;
                T_byte           = 1'b0;
            end
            tick();
            check($sformatf("%s_bit%0d", tag, i), 32'(serial1), 32'(exp[i]));
        end
        check({tag, "_still_sending"}, 32'(dut1.state), 32'(ST_SENDING));
        tick();
        check({tag, "_idle_after"}, 32'(dut1.state), 32'(ST_IDLE));
        check({tag, "_line_high_after"}, 32'(serial1), 32'd1);
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset            = 1'b0;
        Data_Bus         = 8'h00;
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b0;

        // Reset and idle
        tick();
        tick();
        check("rst_line", 32'(serial1), 32'd1);
        check("rst_state", 32'(dut1.state), 32'(ST_IDLE));
        check("rst_datareg", 32'(dut1.XMT_datareg), 32'h00);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_line", 32'(serial1), 32'd1);
            check("idle_state", 32'(dut1.state), 32'(ST_IDLE));
        end

        // Send 0x41 with bypass load
        Data_Bus         = 8'h41;
        Load_XMT_datareg = 1'b1;
        Byte_ready       = 1'b1;
        tick();
        check("a_waiting", 32'(dut1.state), 32'(ST_WAITING));
        check("a_wait_line", 32'(serial1), 32'd1);
        check("a_datareg", 32'(dut1.XMT_datareg), 32'h41);
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b1;
        tick();
        T_byte = 1'b0;
        run_frame("a", FRAME_41, 1'b0);

        // Preloaded holding register, then wait in WAITING
        Data_Bus         = 8'hA5;
        Load_XMT_datareg = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Data_Bus         = 8'h00;
        T_byte           = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_idle_ignores_tbyte", 32'(dut1.state), 32'(ST_IDLE));
            check("pre_idle_line", 32'(serial1), 32'd1);
        end
        T_byte     = 1'b0;
        Byte_ready = 1'b1;
        tick();
        Byte_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("pre_wait_state", 32'(dut1.state), 32'(ST_WAITING));
            check("pre_wait_line", 32'(serial1), 32'd1);
        end
        T_byte = 1'b1;
        tick();
        T_byte = 1'b0;
        run_frame("pre", FRAME_A5, 1'b0);

        // Inputs poked mid-frame must not disturb it
        Data_Bus         = 8'h3C;
        Load_XMT_datareg = 1'b1;
        Byte_ready       = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b1;
        tick();
        T_byte = 1'b0;
        run_frame("ign", FRAME_3C, 1'b1);
        check("ign_datareg", 32'(dut1.XMT_datareg), 32'hFF);

        // Reset at d3 aborts the frame
        Data_Bus         = 8'h41;
        Load_XMT_datareg = 1'b1;
        Byte_ready       = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b1;
        tick();
        T_byte = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_d3", 32'(serial1), 32'(FRAME_41[4]));
        check("mid_sending", 32'(dut1.state), 32'(ST_SENDING));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_line", 32'(serial1), 32'd1);
        check("mid_rst_state", 32'(dut1.state), 32'(ST_IDLE));
        Data_Bus         = 8'h96;
        Load_XMT_datareg = 1'b1;
        Byte_ready       = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b1;
        tick();
        T_byte = 1'b0;
        run_frame("post", FRAME_96, 1'b0);

        // Slow bit rate on the CLKS_PER_BIT=4 instance
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("slow_idle", 32'(dut4.state), 32'(ST_IDLE));
        Data_Bus         = 8'h41;
        Load_XMT_datareg = 1'b1;
        Byte_ready       = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b1;
        tick();
        T_byte = 1'b0;
        check("slow_start", 32'(serial4), 32'd0);
        for (int i = 1; i < 40; i++) begin
            tick();
            check($sformatf("slow_cyc%0d", i), 32'(serial4), 32'(FRAME_41[i / 4]));
        end
        check("slow_sending_s39", 32'(dut4.state), 32'(ST_SENDING));
        tick();
        check("slow_idle_s40", 32'(dut4.state), 32'(ST_IDLE));
        check("slow_line_s40", 32'(serial4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
